// File: rtl/fifo_wr_gen_pkg.sv
// Shared encodings and defaults for the FIFO write-side generator and its
// read-side checker.
package fifo_wr_gen_pkg;

    // Pattern select encodings
    localparam logic MODE_CNT  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Write-side control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Default 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) and its start value
    localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'h01;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with asynchronous active-low reset.
// Shared by the write-side generator and the read-side checker.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_gen.sv
// FIFO write-side traffic generator: waits for the FIFO to drain, then writes
// a burst of counter or LFSR data, stopping on burst count, almost_full/full,
// enable drop or write-reset busy. The data stream is continuous across bursts.
module fifo_wr_gen
    import fifo_wr_gen_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                WRAP_VAL    = 254,
    parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(LFSR_TAPS_DEF),
    parameter logic [DATA_W-1:0] LFSR_SEED   = DATA_W'(LFSR_SEED_DEF),
    parameter int                SYNC_STAGES = 2,
    parameter int                CNT_W       = 16
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              empty,
    input  logic              almost_full,
    input  logic              full,
    input  logic              wr_rst_busy,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic              burst_done,
    output logic              overflow_err
);

    // Only empty crosses domains; every other input is already on wr_clk
    logic empty_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_empty_sync (
        .clk_i  (wr_clk),
        .rst_ni (rst_n),
        .d_i    (empty),
        .q_o    (empty_s)
    );

    state_e            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] data_q, data_d, data_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  blen_q, blen_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              start;
    logic              burst_last;

    // Counter pattern: 0..WRAP_VAL; anything at or above the wrap value
    // (e.g. after a width change) folds back to 0
    function automatic logic [DATA_W-1:0] cnt_next(input logic [DATA_W-1:0] v);
        if (v >= DATA_W'(WRAP_VAL)) begin
            return '0;
        end
        return v + DATA_W'(1);
    endfunction

    // Galois LFSR step; a zero state (left over from counter mode) reseeds
    // so the generator can never lock up
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        if (v == '0) begin
            return LFSR_SEED;
        end
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    // The write currently on the port is the last one of a counted burst
    assign burst_last = (blen_q != '0) && (cnt_q == blen_q - CNT_W'(1));

    // Control FSM: next state, write enable, burst-done and burst latches
    always_comb begin
        state_d = state_q;
        wr_en_d = wr_en_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        blen_d  = blen_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en_d = 1'b0;
                if (enable && !wr_rst_busy) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                wr_en_d = 1'b0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (empty_s && !wr_rst_busy) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
                    start   = 1'b1;
                    mode_d  = mode;
                    blen_d  = burst_len;
                end
            end
            WRITE: begin
                if (!enable) begin
                    // Operator stop: silent, no burst_done
                    wr_en_d = 1'b0;
                    state_d = IDLE;
                end else if (almost_full || full) begin
                    wr_en_d = 1'b0;
                    state_d = ARM;
                    done_d  = 1'b1;
                end else if (wr_en_q && burst_last) begin
                    wr_en_d = 1'b0;
                    state_d = ARM;
                    done_d  = 1'b1;
                end
            end
            default: begin
                wr_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        // Write-reset busy overrides everything, in any state
        if (wr_rst_busy) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // Datapath: pattern advance on accepted writes, burst counter, overflow
    always_comb begin
        data_next = (mode_q == MODE_LFSR) ? lfsr_next(data_q) : cnt_next(data_q);
        data_d    = data_q;
        cnt_d     = cnt_q;
        if (start) begin
            // start only fires from ARM, where no write is in flight
            cnt_d = '0;
            if (mode != mode_q) begin
                data_d = (mode == MODE_LFSR) ? LFSR_SEED : '0;
            end
        end else if (wr_en_q) begin
            data_d = data_next;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        ovf_d = ovf_q | (wr_en_q & full);
    end

    // State and output registers
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            blen_q  <= '0;
            mode_q  <= MODE_CNT;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            blen_q  <= blen_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = data_q;
    assign wr_count     = cnt_q;
    assign burst_done   = done_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Directed bench for fifo_wr_gen: cycle tables for the counter and LFSR bursts,
// hand sequences for wrap, burst restart, write-reset busy, overflow and
// asynchronous reset.
module tb_fifo_wr_gen;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              wr_clk = 1'b0;
    logic              rst_n, enable, mode, empty, almost_full, full, wr_rst_busy;
    logic [CNT_W-1:0]  burst_len;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [CNT_W-1:0]  wr_count;
    logic              burst_done, overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_gen #(
        .DATA_W      (DATA_W),
        .WRAP_VAL    (254),
        .LFSR_TAPS   (8'hB8),
        .LFSR_SEED   (8'h01),
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .burst_len    (burst_len),
        .empty        (empty),
        .almost_full  (almost_full),
        .full         (full),
        .wr_rst_busy  (wr_rst_busy),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .wr_count     (wr_count),
        .burst_done   (burst_done),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic              r, e, m;
        logic [CNT_W-1:0]  bl;
        logic              em, af, f, b;
        logic              x_en;
        logic [DATA_W-1:0] x_data;
        logic [CNT_W-1:0]  x_cnt;
        logic              x_done, x_ovf;
        int                tag;
    } vec_t;

    vec_t vecs[$];

    // Hand-derived LFSR sequence for taps 0xB8 from seed 0x01
    localparam logic [7:0] LFSR_EXP [10] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17,
                                             8'hB3, 8'hE1, 8'hC8, 8'h64, 8'h32};

    function automatic void add(input logic r, input logic e, input logic m,
                                input logic [CNT_W-1:0] bl, input logic em,
                                input logic af, input logic f, input logic b,
                                input logic xe, input logic [DATA_W-1:0] xd,
                                input logic [CNT_W-1:0] xc, input logic xdn,
                                input logic xo, input int tag);
        vec_t v;
        v.r = r; v.e = e; v.m = m; v.bl = bl; v.em = em; v.af = af; v.f = f; v.b = b;
        v.x_en = xe; v.x_data = xd; v.x_cnt = xc; v.x_done = xdn; v.x_ovf = xo;
        v.tag = tag;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; burst_len = '0; empty = 1'b1;
        almost_full = 1'b0; full = 1'b0; wr_rst_busy = 1'b0;
        step();
        step();
    endtask

    task automatic wait_wr_en(input string name, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (fifo_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: fifo_wr_en got 0 expected 1 within %0d cycles", name, max);
        end
    endtask

    initial begin
        int  writes, dones, first, bad;
        bit  ok, flag, seen_wrap, saw_ff;
        logic [DATA_W-1:0] exp_d, prev;

        // ---- table 1: counter burst stopped by almost_full ----
        add(1'b0,1'b0,1'b0,16'd0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'd0,16'd0,1'b0,1'b0, 1);
        add(1'b0,1'b0,1'b0,16'd0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'd0,16'd0,1'b0,1'b0, 1);
        for (int i = 1; i <= 26; i++) begin
            if (i < 3)
                add(1'b1,1'b1,1'b0,16'd0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'd0,16'd0,1'b0,1'b0, 1);
            else if (i <= 23)
                add(1'b1,1'b1,1'b0,16'd0,(i <= 3),1'b0,1'b0,1'b0,
                    1'b1,8'(i-3),16'(i-3),1'b0,1'b0, 1);
            else
                add(1'b1,1'b1,1'b0,16'd0,1'b0,1'b1,1'b0,1'b0,
                    1'b0,8'd21,16'd21,(i == 24),1'b0, 1);
        end
        // ---- table 2: LFSR burst of 10 ----
        add(1'b0,1'b0,1'b0,16'd0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'd0,16'd0,1'b0,1'b0, 2);
        for (int i = 1; i <= 14; i++) begin
            if (i < 3)
                add(1'b1,1'b1,1'b1,16'd10,1'b1,1'b0,1'b0,1'b0, 1'b0,8'd0,16'd0,1'b0,1'b0, 2);
            else if (i <= 12)
                add(1'b1,1'b1,1'b1,16'd10,(i <= 3),1'b0,1'b0,1'b0,
                    1'b1,LFSR_EXP[i-3],16'(i-3),1'b0,1'b0, 2);
            else
                add(1'b1,1'b1,1'b1,16'd10,1'b0,1'b0,1'b0,1'b0,
                    1'b0,8'h19,16'd10,(i == 13),1'b0, 2);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].r; enable = vecs[i].e; mode = vecs[i].m; burst_len = vecs[i].bl;
            empty = vecs[i].em; almost_full = vecs[i].af; full = vecs[i].f;
            wr_rst_busy = vecs[i].b;
            step();
            checks++;
            if (fifo_wr_en !== vecs[i].x_en || fifo_wr_data !== vecs[i].x_data ||
                wr_count !== vecs[i].x_cnt || burst_done !== vecs[i].x_done ||
                overflow_err !== vecs[i].x_ovf) begin
                errors++;
                $display("FAIL vec%0d (table %0d): got en=%b data=%h cnt=%0d done=%b ovf=%b expected en=%b data=%h cnt=%0d done=%b ovf=%b",
                         i, vecs[i].tag, fifo_wr_en, fifo_wr_data, wr_count, burst_done,
                         overflow_err, vecs[i].x_en, vecs[i].x_data, vecs[i].x_cnt,
                         vecs[i].x_done, vecs[i].x_ovf);
            end
        end

        // ---- counter wrap: ...,253,254,0,1 and never 255 ----
        do_reset();
        rst_n = 1'b1; enable = 1'b1;
        wait_wr_en("wrap_start", 10, ok);
        empty = 1'b0;
        exp_d = '0; prev = '0; bad = 0; seen_wrap = 1'b0; saw_ff = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (fifo_wr_data !== exp_d || fifo_wr_en !== 1'b1) bad++;
            if (fifo_wr_data == 8'hFF) saw_ff = 1'b1;
            if (k > 0 && prev == 8'd254 && fifo_wr_data == 8'd0) seen_wrap = 1'b1;
            prev  = fifo_wr_data;
            exp_d = (exp_d == 8'd254) ? 8'd0 : exp_d + 8'd1;
            step();
        end
        chk("wrap_seq_mismatches", bad, 0);
        chk("wrap_254_to_0", seen_wrap, 1);
        chk("wrap_no_255", saw_ff, 0);
        chk("wrap_count", wr_count, 300);

        // ---- burst restart: two bursts of 4, contiguous data ----
        do_reset();
        rst_n = 1'b1; enable = 1'b1; burst_len = 16'd4;
        writes = 0; dones = 0; first = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (fifo_wr_en) begin
                if (first < 0) first = c;
                chk("restart_data", fifo_wr_data, writes);
                writes++;
                empty = 1'b0;
            end
            if (burst_done) begin
                dones++;
                if (dones == 1) empty = 1'b1;
            end
        end
        chk("latency_edges", first + 1, 3);
        chk("restart_writes", writes, 8);
        chk("restart_dones", dones, 2);
        chk("restart_count", wr_count, 4);

        // ---- wr_rst_busy mid-burst ----
        do_reset();
        rst_n = 1'b1; enable = 1'b1;
        wait_wr_en("busy_start", 10, ok);
        empty = 1'b0;
        repeat (5) step();
        chk("busy_pre_data", fifo_wr_data, 5);
        wr_rst_busy = 1'b1;
        step();
        chk("busy_en_fall", fifo_wr_en, 0);
        chk("busy_data_after", fifo_wr_data, 6);
        flag = burst_done;
        repeat (4) begin
            step();
            if (burst_done || fifo_wr_en) flag = 1'b1;
        end
        chk("busy_no_done_no_wr", flag, 0);
        chk("busy_data_hold", fifo_wr_data, 6);
        chk("busy_cnt_hold", wr_count, 6);
        wr_rst_busy = 1'b0; empty = 1'b1;
        wait_wr_en("busy_resume", 20, ok);
        if (ok) chk("busy_resume_data", fifo_wr_data, 6);

        // ---- overflow sticky, then async reset mid-burst ----
        do_reset();
        rst_n = 1'b1; enable = 1'b1;
        wait_wr_en("ovf_start", 10, ok);
        empty = 1'b0;
        chk("ovf_clear", overflow_err, 0);
        full = 1'b1;
        step();
        chk("ovf_set", overflow_err, 1);
        chk("ovf_full_stop", fifo_wr_en, 0);
        chk("ovf_full_done", burst_done, 1);
        full = 1'b0;
        repeat (5) step();
        chk("ovf_sticky", overflow_err, 1);
        empty = 1'b1;
        wait_wr_en("ovf_rearm", 20, ok);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", fifo_wr_en, 0);
        chk("arst_data", fifo_wr_data, 0);
        chk("arst_count", wr_count, 0);
        chk("arst_done", burst_done, 0);
        chk("arst_ovf", overflow_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_gen.md
Name: fifo_wr_gen

Overview:
- Parametrised FIFO write-side traffic generator. It is the successor of the fixed 8-bit incrementing FIFO writer.
- Sits on the write clock domain of an IP FIFO test design. It feeds the FIFO write port, and a matching read-side checker sits on the other side.
- Adds the following over the fixed writer:
  - configurable data width and wrap value;
  - selectable pattern mode (incrementing counter or Galois LFSR);
  - programmable burst length;
  - a full-flag safeguard;
  - a write counter, a burst-done pulse and a sticky overflow error.

Parameters:
- DATA_W, 8, width of fifo_wr_data.
- WRAP_VAL, 254, last counter value before wrapping to 0 (counter mode).
- LFSR_TAPS, 8'hB8, Galois feedback mask, DATA_W bits wide; must be nonzero.
- LFSR_SEED, 1, LFSR start value; must be nonzero.
- SYNC_STAGES, 2, flip-flop depth of the empty synchroniser (at least 2).
- CNT_W, 16, width of burst_len and wr_count.

Ports:
- wr_clk  in  1  write clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  generator enable
- mode  in  1  pattern select: 0 = counter, 1 = LFSR; sampled at burst start
- burst_len  in  CNT_W  writes per burst; 0 = write until almost_full; sampled at burst start
- empty  in  1  FIFO empty flag, read clock domain, asynchronous to wr_clk
- almost_full  in  1  FIFO almost-full flag, wr_clk domain
- full  in  1  FIFO full flag, wr_clk domain
- wr_rst_busy  in  1  FIFO write-reset busy
- fifo_wr_en  out  1  FIFO write enable, registered
- fifo_wr_data  out  DATA_W  FIFO write data, registered
- wr_count  out  CNT_W  accepted writes in the current burst
- burst_done  out  1  one-cycle pulse at burst end
- overflow_err  out  1  sticky error: fifo_wr_en was high while full was high

Behaviour:
- Clocking and reset:
  - One clock (wr_clk). Reset is asynchronous and active-low (rst_n).
  - Reset values: fifo_wr_en=0, fifo_wr_data=0, wr_count=0, burst_done=0, overflow_err=0, FSM=IDLE, synchroniser flops=0, latched mode=0.
- Empty synchroniser: empty passes through SYNC_STAGES flops; its output is empty_s. No other input is synchronised.
- FSM states:
  - IDLE: fifo_wr_en=0. Go to ARM when enable=1 and wr_rst_busy=0.
  - ARM: wait for the FIFO to drain. When empty_s=1, enable=1 and wr_rst_busy=0:
    - go to WRITE and set fifo_wr_en<=1;
    - clear wr_count;
    - latch mode and burst_len;
    - if the latched mode differs from the previous one, load fifo_wr_data with its start value (0 for counter, LFSR_SEED for LFSR).
  - WRITE: fifo_wr_en stays 1 until a stop condition is registered. Stop conditions:
    - almost_full=1;
    - full=1;
    - burst_len!=0 and wr_count==burst_len-1 during a write cycle;
    - enable=0.
  - On stop: fifo_wr_en<=0; go to ARM, or to IDLE if enable=0.
  - burst_done pulses on the cycle fifo_wr_en falls due to a burst-count or almost_full/full stop. It does not pulse for enable or wr_rst_busy stops.
- wr_rst_busy=1 in any state forces fifo_wr_en<=0 and FSM<=IDLE on the next edge. wr_count and data are retained.
- Latency: an empty rising edge produces fifo_wr_en high SYNC_STAGES+1 wr_clk edges later (worst case +1 for metastability).
- Data advance: on every edge where fifo_wr_en=1 (a write accepted), fifo_wr_data advances; otherwise it holds.
  - Counter mode: if data>=WRAP_VAL the next value is 0, else data+1. The sequence is 0..WRAP_VAL, so the period is WRAP_VAL+1.
  - LFSR mode: next = (data>>1) ^ (data[0] ? LFSR_TAPS : 0). If data==0, LFSR_SEED is loaded instead, so the LFSR never locks up.
  - Data continues across bursts, giving the checker a continuous stream.
- wr_count increments on every accepted write and saturates at all-ones.
- Burst length: with burst_len=N, exactly N writes occur, unless almost_full stops the burst earlier.
- Because fifo_wr_en is registered, one additional write may land the cycle after almost_full rises. The FIFO's almost-full threshold must leave at least 1 free entry.
- overflow_err: set when fifo_wr_en=1 and full=1 on the same edge; cleared only by rst_n.
- Simultaneous events, in priority order: wr_rst_busy, then enable=0, then full/almost_full, then burst count.
- Reset mid-burst returns every output to its reset value immediately (asynchronous assertion).

Decomposition:
- Shared package holds:
  - mode encodings MODE_CNT=0 and MODE_LFSR=1;
  - FSM state enum (IDLE, ARM, WRITE);
  - default LFSR taps and seed constants.
- One natural sub-module, sync_ff: a parametrised N-stage single-bit synchroniser with asynchronous active-low reset. It is reusable by the read-side checker.

Test Plan:
- Counter basic: reset, enable=1, burst_len=0, empty=1, almost_full asserted after 20 writes -> fifo_wr_en rises 3 edges after enable. Data runs 0,1,...,19 (plus at most 1 extra write), then burst_done pulses once.
- Counter wrap: DATA_W=8, WRAP_VAL=254, long burst -> data runs ...,253,254,0,1. Value 255 never appears.
- LFSR mode: mode=1, burst_len=10 -> exactly 10 writes, starting 0x01 then 0xB8,0x5C,0x2E,0x17; wr_count=10; one burst_done pulse.
- Burst restart: burst_len=4, two bursts separated by empty toggling 0->1 -> 8 total writes, counter data contiguous 0..7, two burst_done pulses.
- wr_rst_busy mid-burst: assert wr_rst_busy for 5 cycles during WRITE -> fifo_wr_en falls the next edge and there is no burst_done. After release, the FSM re-arms and resumes with data continuing from the held value.
- Overflow: force full=1 while fifo_wr_en=1 -> overflow_err sets and stays 1 until rst_n; async reset mid-burst clears all outputs without a clock.
